// File: rtl/floo_latency_model.sv
// Multi-channel memory-latency model: per-channel in-order FIFOs that release each entry
// once a shared free-running cycle counter reaches the entry's due time.

module floo_latency_model_chk #(
  parameter int unsigned NumChannels = 1,
  parameter int unsigned DataWidth   = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumChannels-1:0]           out_valid_i,
  input  logic [NumChannels-1:0]           out_ready_i,
  input  logic [NumChannels*DataWidth-1:0] out_data_i
);

  logic [NumChannels-1:0]           hold_r;
  logic [NumChannels*DataWidth-1:0] data_r;

  // remember which channels stalled a presented response last cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_r <= '0;
      data_r <= '0;
    end else begin
      hold_r <= out_valid_i & ~out_ready_i;
      data_r <= out_data_i;
    end
  end

  // a stalled head must stay valid and stable; this also trips if a head outlives the wrap window
  always @(posedge clk_i) begin
    for (int c = 0; c < NumChannels; c++) begin
      if (rst_ni && hold_r[c]) begin
        assert (out_valid_i[c] && (out_data_i[c*DataWidth +: DataWidth] == data_r[c*DataWidth +: DataWidth]))
          else $error("floo_latency_model: stalled response on channel %0d changed or dropped", c);
      end
    end
  end

endmodule

module floo_latency_model #(
  parameter int unsigned NumChannels    = 1,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxTxns        = 32,
  parameter int unsigned MaxLatency     = 255,
  parameter int unsigned DefaultLatency = 100,
  parameter int unsigned LatWidth       = $clog2(MaxLatency + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             lat_we_i,
  input  logic [LatWidth-1:0]              lat_i,
  input  logic [NumChannels-1:0]           in_valid_i,
  output logic [NumChannels-1:0]           in_ready_o,
  input  logic [NumChannels*DataWidth-1:0] in_data_i,
  output logic [NumChannels-1:0]           out_valid_o,
  input  logic [NumChannels-1:0]           out_ready_i,
  output logic [NumChannels*DataWidth-1:0] out_data_o,
  output logic [NumChannels-1:0]           busy_o
);

  // one extra bit so a signed age distinguishes "not yet due" from "overdue" across wrap
  localparam int unsigned TW = LatWidth + 1;
  localparam int unsigned PW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned CW = $clog2(MaxTxns + 1);

  function automatic logic [LatWidth-1:0] clamp_lat(input logic [LatWidth-1:0] v);
    logic [LatWidth-1:0] r;
    if (v == '0) begin
      r = LatWidth'(1);
    end else if (v > LatWidth'(MaxLatency)) begin
      r = LatWidth'(MaxLatency);
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MaxTxns - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [TW-1:0]       now_r;
  logic [LatWidth-1:0] lat_r;

  // shared time base and latency register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      now_r <= '0;
      lat_r <= LatWidth'(DefaultLatency);
    end else begin
      now_r <= now_r + TW'(1);
      if (lat_we_i) begin
        lat_r <= clamp_lat(lat_i);
      end else begin
        lat_r <= lat_r;
      end
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [DataWidth-1:0] data_mem_r [MaxTxns];
    logic [TW-1:0]        due_mem_r  [MaxTxns];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic [TW-1:0]        age_s;
    logic                 ready_s;
    logic                 valid_s;
    logic                 push_s;
    logic                 pop_s;

    // handshake decode; ready looks only at the registered count, so a full queue never falls through
    always_comb begin
      ready_s = (count_r != CW'(MaxTxns));
      age_s   = now_r - due_mem_r[rd_ptr_r];
      valid_s = (count_r != '0) && !age_s[TW-1];
      push_s  = in_valid_i[c] && ready_s;
      pop_s   = valid_s && out_ready_i[c];
    end

    assign in_ready_o[c]                          = ready_s;
    assign out_valid_o[c]                         = valid_s;
    assign out_data_o[c*DataWidth +: DataWidth]   = valid_s ? data_mem_r[rd_ptr_r] : '0;
    assign busy_o[c]                              = (count_r != '0);

    // entry storage; the due time freezes the latency in force at acceptance
    always_ff @(posedge clk_i) begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= in_data_i[c*DataWidth +: DataWidth];
        due_mem_r[wr_ptr_r]  <= now_r + TW'(lat_r);
      end
    end

    // queue pointers and occupancy
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= next_ptr(wr_ptr_r);
        end
        if (pop_s) begin
          rd_ptr_r <= next_ptr(rd_ptr_r);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  floo_latency_model_chk #(
    .NumChannels (NumChannels),
    .DataWidth   (DataWidth)
  ) i_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .out_valid_i (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_i  (out_data_o)
  );

endmodule

// File: tb/tb_floo_latency_model.sv
// Randomised and directed bench for floo_latency_model; a cycle-level reference model in a
// negedge monitor predicts ready/valid/data/busy for every channel and every cycle.

module tb_floo_latency_model;

  localparam int NC     = 2;
  localparam int DW     = 32;
  localparam int MAXT   = 32;
  localparam int MAXL   = 255;
  localparam int DEFL   = 100;
  localparam int LW     = 8;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lat_we = 1'b0;
  logic [LW-1:0]    lat_i = '0;
  logic [NC-1:0]    in_valid = '0;
  logic [NC-1:0]    in_ready;
  logic [NC*DW-1:0] in_data = '0;
  logic [NC-1:0]    out_valid;
  logic [NC-1:0]    out_ready = '0;
  logic [NC*DW-1:0] out_data;
  logic [NC-1:0]    busy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   lat_m = DEFL;
  ent_t mq [NC][$];

  floo_latency_model #(
    .NumChannels    (NC),
    .DataWidth      (DW),
    .MaxTxns        (MAXT),
    .MaxLatency     (MAXL),
    .DefaultLatency (DEFL)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .lat_we_i    (lat_we),
    .lat_i       (lat_i),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s ch%0d cycle %0d: got %0h expected %0h", nm, c, cyc, act, exp);
    end
  endtask

  function automatic int clamp_lat(input int v);
    if (v < 1) return 1;
    if (v > MAXL) return MAXL;
    return v;
  endfunction

  // reference model: an entry accepted in cycle t may be presented from cycle t+L on, in order
  always @(negedge clk) begin
    logic          ev;
    logic          er;
    logic [DW-1:0] ed;
    ent_t          e;
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
      lat_m = DEFL;
    end else begin
      for (int c = 0; c < NC; c++) begin
        er = (mq[c].size() < MAXT);
        ev = (mq[c].size() > 0) && (cyc >= mq[c][0].due);
        ed = ev ? mq[c][0].data : '0;
        chk("in_ready", c, 64'(in_ready[c]), 64'(er));
        chk("out_valid", c, 64'(out_valid[c]), 64'(ev));
        chk("out_data", c, 64'(out_data[c*DW +: DW]), 64'(ed));
        chk("busy", c, 64'(busy[c]), 64'(mq[c].size() > 0));
        if (ev && out_ready[c]) void'(mq[c].pop_front());
        if (in_valid[c] && er) begin
          e.data = in_data[c*DW +: DW];
          e.due  = cyc + lat_m;
          mq[c].push_back(e);
        end
      end
      if (lat_we) lat_m = clamp_lat(int'(lat_i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = '0;
    lat_we   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_lat(input int v);
    lat_we = 1'b1;
    lat_i  = LW'(v);
    tick();
    lat_we = 1'b0;
  endtask

  task automatic push1(input int c);
    in_valid = '0;
    in_valid[c] = 1'b1;
    in_data[c*DW +: DW] = DW'($urandom);
    tick();
    in_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    out_ready = 2'b11;

    // single push at the default latency
    idle(9);
    push1(0);
    idle(110);

    // latency clamp to 1 and to the maximum
    set_lat(0);
    push1(0);
    idle(5);
    set_lat(255);
    push1(1);
    idle(260);

    // fill ch0 to capacity with no consumer, then pop+push in one cycle while full
    set_lat(5);
    out_ready[0] = 1'b0;
    for (int i = 0; i < MAXT + 1; i++) push1(0);
    idle(10);
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_data[DW-1:0] = DW'($urandom);
    tick();
    idle(45);

    // latency written in the same cycle as A's acceptance; B must queue behind A
    set_lat(50);
    lat_we = 1'b1;
    lat_i  = LW'(5);
    push1(0);
    lat_we = 1'b0;
    push1(0);
    idle(70);

    // ch1 stalled for 300 cycles while ch0 runs at a short latency
    set_lat(200);
    out_ready[1] = 1'b0;
    for (int i = 0; i < 8; i++) push1(1);
    set_lat(10);
    for (int i = 0; i < 290; i++) begin
      in_valid = {1'b0, 1'($urandom_range(0, 1))};
      in_data[DW-1:0] = DW'($urandom);
      tick();
    end
    in_valid = '0;
    out_ready[1] = 1'b1;
    idle(40);

    // reset in the middle of a full-ish queue drops everything
    set_lat(30);
    out_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) push1(0);
    idle(5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 2'b11;
    idle(60);

    // randomised traffic with short latencies and random backpressure
    for (int i = 0; i < 2500; i++) begin
      in_valid = NC'($urandom_range(0, 3));
      in_data  = {DW'($urandom), DW'($urandom)};
      out_ready = {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)};
      lat_we = ($urandom_range(0, 49) == 0);
      lat_i  = LW'($urandom_range(0, 40));
      tick();
    end
    in_valid = '0;
    lat_we = 1'b0;
    out_ready = 2'b11;
    idle(300);

    for (int c = 0; c < NC; c++) chk("drained", c, 64'(mq[c].size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
